// File: rtl/bp_target_select_if.sv
// Fetch-group and prediction-output bundle for bp_target_select.
// master: IF predecode / instruction-queue side. slave: bp_target_select.
interface bp_target_select_if #(
    parameter int unsigned PC_W = 32
);
    logic                grp_valid;
    logic                grp_ready;
    logic [PC_W-1:0]     grp_pc;
    logic [3:0]          slot_valid;
    logic [19:0]         takeDestSel_p;
    logic [3:0]          pht_taken;
    logic [4*PC_W-1:0]   btb_target;
    logic [4*PC_W-1:0]   ijtc_target;
    logic                out_valid;
    logic                out_ready;
    logic                pred_taken;
    logic [PC_W-1:0]     pred_target;
    logic [3:0]          pred_mask;

    modport master (
        output grp_valid, grp_pc, slot_valid, takeDestSel_p, pht_taken,
               btb_target, ijtc_target, out_ready,
        input  grp_ready, out_valid, pred_taken, pred_target, pred_mask
    );

    modport slave (
        input  grp_valid, grp_pc, slot_valid, takeDestSel_p, pht_taken,
               btb_target, ijtc_target, out_ready,
        output grp_ready, out_valid, pred_taken, pred_target, pred_mask
    );
endinterface

// File: rtl/bp_target_select.sv
// Branch target selection for one 4-slot fetch group: finds the first
// predicted-taken slot, chooses BTB / IJTC / RAS target, tracks the MIPS
// delay slot across groups and keeps a speculative RAS with commit copy.
// Optional: define BP_PERF_CNT_EN to add perf_taken_cnt / perf_ras_ovf_cnt.
module bp_target_select #(
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned PC_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bp_target_select_if.slave    bus,
    input  logic                 flush,
    input  logic                 commit_call,
    input  logic                 commit_ret
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]          perf_taken_cnt,
    output logic [31:0]          perf_ras_ovf_cnt
`endif
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [0:0] {StNorm, StWaitDs} state_e;

    state_e            state_q;
    logic              out_valid_q;
    logic              pred_taken_q;
    logic [PC_W-1:0]   pred_target_q;
    logic [3:0]        pred_mask_q;
    logic [PC_W-1:0]   ds_target_q;

    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PtrW-1:0]   spec_ptr_q, cmt_ptr_q, cmt_ptr_d;
    logic [CntW-1:0]   spec_cnt_q, cmt_cnt_q, cmt_cnt_d;

    logic [4:0]        sel [4];
    logic [3:0]        taken;
    logic              any_taken;
    logic [1:0]        k;
    logic              op_found;
    logic [1:0]        op_slot;
    logic              is_call, is_ret;
    logic              ras_empty, ras_full;
    logic [PC_W-1:0]   ras_top, push_val, tgt, btb_k, ijtc_k;
    logic [3:0]        low_mask;
    logic              accept, do_push, do_pop;

    assign bus.grp_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.pred_mask   = pred_mask_q;

    assign accept    = bus.grp_valid && bus.grp_ready && !flush;
    assign ras_empty = (spec_cnt_q == '0);
    assign ras_full  = (spec_cnt_q == CntW'(RAS_DEPTH));
    assign ras_top   = ras_mem[spec_ptr_q - PtrW'(1)];

    // Per-slot decode, first taken slot and the single RAS-operating slot.
    always_comb begin
        any_taken = 1'b0;
        k         = 2'd0;
        op_found  = 1'b0;
        op_slot   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            sel[i]   = bus.takeDestSel_p[5*i +: 5];
            taken[i] = bus.slot_valid[i] && (sel[i][1] || (sel[i][0] && bus.pht_taken[i]));
        end
        for (int i = 3; i >= 0; i--) begin
            if (taken[i]) begin
                any_taken = 1'b1;
                k         = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!op_found && bus.slot_valid[i] && sel[i][4] && (!any_taken || i <= int'(k))) begin
                op_found = 1'b1;
                op_slot  = 2'(i);
            end
        end
    end

    // Target choice for slot k; a call flag wins over a return flag.
    always_comb begin
        is_call  = op_found && sel[op_slot][0];
        is_ret   = op_found && !sel[op_slot][0] && sel[op_slot][1];
        push_val = bus.grp_pc + PC_W'({op_slot, 2'b00}) + PC_W'(8);
        btb_k    = bus.btb_target[PC_W*int'(k) +: PC_W];
        ijtc_k   = bus.ijtc_target[PC_W*int'(k) +: PC_W];
        if (sel[k][2]) begin
            tgt = btb_k;
        end else if (sel[k][3]) begin
            tgt = ijtc_k;
        end else if (sel[k][4] && sel[k][1] && !sel[k][0] && !ras_empty) begin
            tgt = ras_top;
        end else begin
            tgt = btb_k;
        end
        case (k)
            2'd0:    low_mask = 4'b0011;
            2'd1:    low_mask = 4'b0111;
            default: low_mask = 4'b1111;
        endcase
    end

    assign do_push = accept && (state_q == StNorm) && is_call;
    assign do_pop  = accept && (state_q == StNorm) && is_ret && !ras_empty;

    // Commit copy after this cycle's commits, used for the flush restore.
    always_comb begin
        cmt_ptr_d = cmt_ptr_q;
        cmt_cnt_d = cmt_cnt_q;
        if (commit_call && !commit_ret) begin
            cmt_ptr_d = cmt_ptr_q + PtrW'(1);
            if (cmt_cnt_q != CntW'(RAS_DEPTH)) cmt_cnt_d = cmt_cnt_q + CntW'(1);
        end else if (commit_ret && !commit_call && cmt_cnt_q != '0) begin
            cmt_ptr_d = cmt_ptr_q - PtrW'(1);
            cmt_cnt_d = cmt_cnt_q - CntW'(1);
        end
    end

    // RAS pointers and counts, speculative and committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ptr_q <= '0;
            spec_cnt_q <= '0;
            cmt_ptr_q  <= '0;
            cmt_cnt_q  <= '0;
        end else begin
            cmt_ptr_q <= cmt_ptr_d;
            cmt_cnt_q <= cmt_cnt_d;
            if (flush) begin
                spec_ptr_q <= cmt_ptr_d;
                spec_cnt_q <= cmt_cnt_d;
            end else if (do_push) begin
                spec_ptr_q <= spec_ptr_q + PtrW'(1);
                if (!ras_full) spec_cnt_q <= spec_cnt_q + CntW'(1);
            end else if (do_pop) begin
                spec_ptr_q <= spec_ptr_q - PtrW'(1);
                spec_cnt_q <= spec_cnt_q - CntW'(1);
            end
        end
    end

    // RAS storage; circular, so a push when full overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (do_push) ras_mem[spec_ptr_q] <= push_val;
    end

    // Delay-slot FSM with registered prediction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StNorm;
            out_valid_q   <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_mask_q   <= '0;
            ds_target_q   <= '0;
        end else if (flush) begin
            state_q     <= StNorm;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            case (state_q)
                StNorm: begin
                    pred_target_q <= tgt;
                    if (!any_taken) begin
                        pred_taken_q <= 1'b0;
                        pred_mask_q  <= bus.slot_valid;
                    end else if (k != 2'd3) begin
                        pred_taken_q <= 1'b1;
                        pred_mask_q  <= bus.slot_valid & low_mask;
                    end else begin
                        // Branch in slot 3: its delay slot comes with the next group.
                        pred_taken_q <= 1'b0;
                        pred_mask_q  <= bus.slot_valid;
                        ds_target_q  <= tgt;
                        state_q      <= StWaitDs;
                    end
                end
                StWaitDs: begin
                    pred_target_q <= ds_target_q;
                    if (bus.slot_valid[0]) begin
                        pred_taken_q <= 1'b1;
                        pred_mask_q  <= 4'b0001;
                        state_q      <= StNorm;
                    end else begin
                        pred_taken_q <= 1'b0;
                        pred_mask_q  <= 4'b0000;
                    end
                end
                default: state_q <= StNorm;
            endcase
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef BP_PERF_CNT_EN
    // Performance counters; free-running, untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_taken_cnt   <= '0;
            perf_ras_ovf_cnt <= '0;
        end else begin
            if (out_valid_q && bus.out_ready && pred_taken_q) perf_taken_cnt <= perf_taken_cnt + 32'd1;
            if (do_push && ras_full) perf_ras_ovf_cnt <= perf_ras_ovf_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bp_target_select.md
Name: bp_target_select

Overview:
- Consumer side of the per-slot 5-bit branch selector bus produced by the IF predecode stage.
- Takes one 4-instruction fetch group and its selectors, finds the first predicted-taken slot, and picks the predicted target from the BTB, the IJTC or an internal speculative return address stack (RAS).
- Handles the MIPS delay slot, including the case where the delay slot falls in the next fetch group.
- Output is registered toward the instruction queue and drives the IF redirect.

Parameters:
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- PC_W, 32, PC and target width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- grp_valid  in  1  fetch group present
- grp_ready  out  1  group accepted; equals !out_valid | out_ready
- grp_pc  in  PC_W  PC of slot 0; 16-byte aligned
- slot_valid  in  4  per-slot instruction valid
- takeDestSel_p  in  20  packed selectors; slot i = bits [5i+4:5i]
- pht_taken  in  4  per-slot PHT direction
- btb_target  in  4*PC_W  per-slot BTB target; slot i at [PC_W*i +: PC_W]
- ijtc_target  in  4*PC_W  per-slot IJTC target, same packing
- out_valid  out  1  registered prediction valid
- out_ready  in  1  downstream accepts
- pred_taken  out  1  redirect fetch to pred_target
- pred_target  out  PC_W  predicted target
- pred_mask  out  4  slots forwarded downstream
- flush  in  1  backend redirect
- commit_call  in  1  committed call (RAS push)
- commit_ret  in  1  committed return (RAS pop)

Behaviour:
- Selector bits per slot: [0] = PHT direction, [1] = always taken, [2] = BTB dest, [3] = IJTC dest, [4] = RAS.
- Slot classification:
  - Slot taken = slot_valid & ([1] | ([0] & pht_taken)).
  - Call = [4] & [0]: push the slot PC + 8.
  - Return = [4] & [1]: pop.
- k = lowest taken slot.
- Target selection:
  - [2] set: btb_target[k].
  - [3] set: ijtc_target[k].
  - Return: RAS top; if the RAS is empty, fall back to btb_target[k].
- At most one RAS operation per group: the first [4]-flagged valid slot at or below k (or at any slot if nothing is taken). Calls push even when predicted not-taken (link-always semantics).
- RAS overflow: circular; the oldest entry is overwritten, and the occupancy count saturates at RAS_DEPTH.
- RAS pop when empty: pointer is unchanged.
- A commit pointer and count track commit_call and commit_ret. On flush, the speculative pointer and count are restored from the commit copies. The commit_* signals arriving in the same cycle as the flush are applied before the restore.
- FSM states:
  - NORM:
    - No taken slot: pred_taken = 0, pred_mask = slot_valid.
    - k < 3: pred_taken = 1, pred_mask = slots 0..k+1 that are valid.
    - k = 3: pred_taken = 0, pred_mask = slot_valid, target saved; go to WAIT_DS.
  - WAIT_DS:
    - The next accepted group carries the delay slot. Output pred_taken = 1, pred_target = saved target, pred_mask = 0001 (slot 0 only, if valid); return to NORM.
    - Selectors in this group are ignored; no RAS operation.
    - If slot 0 of this group is invalid, stay in WAIT_DS and output mask 0000.
- Latency: 1 cycle from accepted group to out_valid.
- Output hold: outputs are stable while out_valid & !out_ready.
- Flush:
  - Highest priority: clears out_valid and returns the FSM to NORM.
  - A group presented in the flush cycle is dropped (not accepted, no RAS effect).
- Reset values: out_valid = 0, pred_taken = 0, pred_target = 0, pred_mask = 0, FSM = NORM, all RAS pointers and counts = 0.
- grp_ready is combinational from state.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_taken_cnt (increments per accepted output with pred_taken = 1) and perf_ras_ovf_cnt (increments per push while count == RAS_DEPTH).
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Slot 1 = B (sel 00101), pht_taken = 0010, btb_target[1] = 0x80001000, grp_pc = 0x80000000 -> next cycle out_valid = 1, pred_taken = 1, target 0x80001000, pred_mask = 0111.
- Slot 0 = BAL (10001), pht_taken = 0001, btb_target[0] = 0x80002000; later group slot 2 = JR $31 (10010) -> first output target 0x80002000 with the RAS pushed with 0x80000008; second output target 0x80000008, RAS empty again.
- Slot 3 = J (00110), btb 0x9000 -> pred_taken = 0, mask = 1111; next group -> pred_taken = 1, target 0x9000, mask = 0001.
- Nine calls with RAS_DEPTH = 8, then nine returns -> the first eight returns produce PCs in LIFO order (the oldest call is lost); the ninth return uses the BTB fallback; perf_ras_ovf_cnt = 1 when the macro is defined.
- Two speculative calls, one commit_call, then flush -> the RAS count is restored to 1, and the next return yields the committed call PC + 8.
- out_ready held low for 3 cycles with a second group waiting -> outputs stable, grp_ready = 0; when out_ready rises, the second result appears the cycle after acceptance.
